// File: rtl/prog_loader.sv
// Boot loader: receives a header/word/checksum byte stream and writes big-endian
// 32-bit words into instruction memory, holding the CPU until a verified load completes.
module prog_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    logic [15:0]       r_count;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_csum;
    logic [23:0]       r_word_hi;
    logic              r_rx_ready;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;
    logic [15:0]       r_word_cnt;

    logic              w_accept;
    logic [15:0]       w_count_full;
    logic              w_last_word;

    assign w_accept     = rx_valid && r_rx_ready;
    assign w_count_full = {r_count[15:8], rx_data};
    assign w_last_word  = (r_word_cnt == r_count - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_word_hi  <= '0;
            r_rx_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            // NOTE: default-low each cycle so the write strobe is a single-cycle pulse.
            r_im_we <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_HDR_HI;
                        r_rx_ready <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_word_cnt <= '0;
                        r_byte_idx <= '0;
                        r_csum     <= '0;
                    end
                end
                S_HDR_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= rx_data;
                        r_state       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= rx_data;
                        if ({1'b0, w_count_full} > 17'(DEPTH_WORDS)) begin
                            r_state    <= S_ERR;
                            r_rx_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else if (w_count_full == 16'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_word_hi  <= {r_word_hi[15:0], rx_data};
                        // Fourth byte completes the word; the address uses the pre-increment count.
                        if (r_byte_idx == 2'd3) begin
                            r_im_wdata <= {r_word_hi, rx_data};
                            r_im_addr  <= ADDR_W'({r_word_cnt, 2'b00});
                            r_im_we    <= 1'b1;
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (w_last_word) r_state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_csum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign err      = r_err;
    assign word_cnt = r_word_cnt;

endmodule
